bicubic_coord_gen: RTL and testbench
====================================

BICUBIC_COORD_GEN -- requirements
Module: bicubic_coord_gen

Interface
REQ-001 clk  in  1  system clock; all state updates on its rising edge.
REQ-002 rst  in  1  reset, synchronous, active-high.
REQ-003 cfg_valid  in  1  start-frame strobe; sampled only in IDLE.
REQ-004 src_w, src_h  in  7 each  source image size, legal 1..100.
REQ-005 dst_w, dst_h  in  8 each  output image size, legal 1..255.
REQ-006 step_x, step_y  in  16 each  unsigned Q8.8 source increment per output column/row.
REQ-007 busy  out  1  high from frame accept until frame_done.
REQ-008 req_valid  out  1  request to the bicubic engine is valid.
REQ-009 req_ready  in  1  engine accepts the request.
REQ-010 nb_x, nb_y  out  28 each  four packed 7-bit clamped source indices; [6:0] is index 0.
REQ-011 xh, xv  out  32 each  four packed Q0.8 weight vectors {X3,X2,X1,X0}, with X0=t^3, X1=t^2, X2=t, X3=8'hFF.
REQ-012 out_col, out_row  out  8 each  destination coordinate of the current request.
REQ-013 frame_done  out  1  one-cycle pulse after the last request is accepted.

Function
REQ-014 The FSM SHALL have exactly four states: IDLE, POW, CUBE, ISSUE.
REQ-015 IDLE: on cfg_valid, latch all cfg inputs, clear col/row counters and both accumulators, and go to POW; otherwise stay.
REQ-016 Accumulators acc_x and acc_y SHALL be 17-bit unsigned Q9.8, with integer part i = acc[16:8] and fraction t = acc[7:0].
REQ-017 POW (1 cycle): register t2 = (t*t + 128) >> 8 per axis, 8-bit result; go to CUBE.
REQ-018 CUBE (1 cycle): register t3 = (t2*t + 128) >> 8 per axis; register nb indices and weight vectors; go to ISSUE.
REQ-019 Neighbour index k (k=0..3) SHALL be i-1+k, clamped to [0, size-1]; if i >= size, all four indices SHALL be size-1.
REQ-020 ISSUE: req_valid=1; all request outputs SHALL be held stable while req_ready=0.
REQ-021 When req_valid and req_ready are both high at an edge, the block SHALL advance in raster order:
- not the last column: col+1, acc_x += step_x.
- last column: col=0, acc_x=0, row+1, acc_y += step_y.
REQ-022 After an accepted non-final request, the next state SHALL be POW, giving a 3-cycle minimum request spacing.
REQ-023 On acceptance of the final pixel (col=dst_w-1 and row=dst_h-1): go to IDLE, pulse frame_done for 1 cycle, and drop busy in the same cycle as frame_done.
REQ-024 The first req_valid SHALL assert 3 cycles after the cfg_valid accept edge.
REQ-025 cfg_valid SHALL be ignored in POW, CUBE and ISSUE.
REQ-026 Accumulator addition SHALL saturate at 17'h1FFFF and never wrap.
REQ-027 req_valid SHALL be low in IDLE, POW and CUBE.
REQ-028 out_col/out_row SHALL equal the counters of the pixel whose data is presented.

Reset
REQ-029 rst SHALL force at the next edge: state=IDLE, busy=0, req_valid=0, frame_done=0, and all counters, accumulators and data outputs to 0.
REQ-030 rst asserted mid-frame SHALL abandon the frame with no frame_done pulse.
REQ-031 rst SHALL take priority over cfg_valid and req_ready in the same cycle.

Verification
REQ-032 src_w=4, dst_w=8, step_x=0x0080, dst_h=1, req_ready=1 -> expected requests:
- col0: nb_x={0,0,1,2}, xh=0xFF000000.
- col1: t=0x80, t2=0x40, t3=0x20, xh=0xFF804020.
- col7: nb_x={2,3,3,3}.
- frame_done after col7.
REQ-033 Hold req_ready=0 for 5 cycles in ISSUE -> req_valid stays 1 and nb_x/xh/out_col stay unchanged; advance happens on the first ready edge.
REQ-034 Fraction t=0xFF (step_x=0x00FF, col1) -> t2=0xFE, t3=0xFD, xh=0xFFFFFEFD.
REQ-035 dst_w=dst_h=1 -> exactly one request at cycle cfg+3, then frame_done pulse, then busy=0; a cfg_valid pulse during busy starts no second frame.
REQ-036 rst during ISSUE of row 2 -> next cycle busy=0, req_valid=0, outputs 0, no frame_done; a following cfg_valid restarts at col0/row0.
REQ-037 step_x=0xFFFF, src_w=100, dst_w=255 -> acc_x saturates without wrap, and all nb_x indices =99 once i >= 100.

Source files
------------

// File: rtl/bicubic_coord_gen.sv
// Bicubic coordinate generator: walks the destination raster, maps each pixel to
// clamped 4-tap source neighbourhoods and Q0.8 power-of-fraction weight vectors.
module bicubic_coord_gen (
  input  logic        clk,
  input  logic        rst,
  input  logic        cfg_valid,
  input  logic [6:0]  src_w,
  input  logic [6:0]  src_h,
  input  logic [7:0]  dst_w,
  input  logic [7:0]  dst_h,
  input  logic [15:0] step_x,
  input  logic [15:0] step_y,
  output logic        busy,
  output logic        req_valid,
  input  logic        req_ready,
  output logic [27:0] nb_x,
  output logic [27:0] nb_y,
  output logic [31:0] xh,
  output logic [31:0] xv,
  output logic [7:0]  out_col,
  output logic [7:0]  out_row,
  output logic        frame_done
);

  typedef enum logic [1:0] {IDLE, POW, CUBE, ISSUE} state_t;

  state_t      state_reg;
  logic [6:0]  src_w_reg, src_h_reg;
  logic [7:0]  dst_w_reg, dst_h_reg;
  logic [15:0] step_x_reg, step_y_reg;
  logic [7:0]  col_reg, row_reg;
  logic [16:0] acc_x_reg, acc_y_reg;
  logic [7:0]  t2x_reg, t2y_reg;

  logic [8:0]  ix, iy;
  logic [7:0]  tx, ty;
  logic [15:0] sq_x, sq_y, cu_x, cu_y;
  logic [27:0] nbx_next, nby_next;
  logic        last_col, last_row;

  // Clamped neighbour index i-1+k; an integer part past the edge pins all taps to size-1.
  function automatic logic [6:0] clamp_idx(input logic [8:0] i, input logic [1:0] k,
                                           input logic [6:0] size);
    logic [9:0] ik;
    ik = {1'b0, i} + {8'b0, k};
    if (i >= {2'b0, size})
      return size - 7'd1;
    else if (ik == 10'd0)
      return 7'd0;
    else if (ik > {3'b0, size})
      return size - 7'd1;
    else
      return 7'(ik - 10'd1);
  endfunction

  function automatic logic [16:0] sat_add(input logic [16:0] a, input logic [15:0] b);
    logic [17:0] s;
    s = {1'b0, a} + {2'b0, b};
    return s[17] ? 17'h1FFFF : s[16:0];
  endfunction

  assign ix = acc_x_reg[16:8];
  assign iy = acc_y_reg[16:8];
  assign tx = acc_x_reg[7:0];
  assign ty = acc_y_reg[7:0];

  // Rounded Q0.8 products; the largest value (255*255+128) still fits 16 bits.
  assign sq_x = 16'(tx) * 16'(tx) + 16'd128;
  assign sq_y = 16'(ty) * 16'(ty) + 16'd128;
  assign cu_x = 16'(t2x_reg) * 16'(tx) + 16'd128;
  assign cu_y = 16'(t2y_reg) * 16'(ty) + 16'd128;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_nb
      assign nbx_next[gi*7 +: 7] = clamp_idx(ix, 2'(gi), src_w_reg);
      assign nby_next[gi*7 +: 7] = clamp_idx(iy, 2'(gi), src_h_reg);
    end
  endgenerate

  assign last_col = (col_reg == dst_w_reg - 8'd1);
  assign last_row = (row_reg == dst_h_reg - 8'd1);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg  <= IDLE;
      src_w_reg  <= '0;
      src_h_reg  <= '0;
      dst_w_reg  <= '0;
      dst_h_reg  <= '0;
      step_x_reg <= '0;
      step_y_reg <= '0;
      col_reg    <= '0;
      row_reg    <= '0;
      acc_x_reg  <= '0;
      acc_y_reg  <= '0;
      t2x_reg    <= '0;
      t2y_reg    <= '0;
      busy       <= 1'b0;
      req_valid  <= 1'b0;
      frame_done <= 1'b0;
      nb_x       <= '0;
      nb_y       <= '0;
      xh         <= '0;
      xv         <= '0;
      out_col    <= '0;
      out_row    <= '0;
    end else begin
      frame_done <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (cfg_valid) begin
            src_w_reg  <= src_w;
            src_h_reg  <= src_h;
            dst_w_reg  <= dst_w;
            dst_h_reg  <= dst_h;
            step_x_reg <= step_x;
            step_y_reg <= step_y;
            col_reg    <= '0;
            row_reg    <= '0;
            acc_x_reg  <= '0;
            acc_y_reg  <= '0;
            busy       <= 1'b1;
            state_reg  <= POW;
          end
        end
        POW: begin
          t2x_reg   <= sq_x[15:8];
          t2y_reg   <= sq_y[15:8];
          state_reg <= CUBE;
        end
        CUBE: begin
          xh        <= {8'hFF, tx, t2x_reg, cu_x[15:8]};
          xv        <= {8'hFF, ty, t2y_reg, cu_y[15:8]};
          nb_x      <= nbx_next;
          nb_y      <= nby_next;
          out_col   <= col_reg;
          out_row   <= row_reg;
          req_valid <= 1'b1;
          state_reg <= ISSUE;
        end
        ISSUE: begin
          // Everything presented stays frozen until the engine takes it.
          if (req_ready) begin
            req_valid <= 1'b0;
            if (last_col) begin
              col_reg   <= '0;
              acc_x_reg <= '0;
              if (last_row) begin
                busy       <= 1'b0;
                frame_done <= 1'b1;
                state_reg  <= IDLE;
              end else begin
                row_reg   <= row_reg + 8'd1;
                acc_y_reg <= sat_add(acc_y_reg, step_y_reg);
                state_reg <= POW;
              end
            end else begin
              col_reg   <= col_reg + 8'd1;
              acc_x_reg <= sat_add(acc_x_reg, step_x_reg);
              state_reg <= POW;
            end
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bicubic_coord_gen.sv
// Directed bench for bicubic_coord_gen: raster walk, stalls, fraction extremes,
// single-pixel frames, mid-frame reset and accumulator saturation.
module tb_bicubic_coord_gen;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cfg_valid = 1'b0;
  logic [6:0]  src_w = '0, src_h = '0;
  logic [7:0]  dst_w = '0, dst_h = '0;
  logic [15:0] step_x = '0, step_y = '0;
  logic        busy, req_valid;
  logic        req_ready = 1'b0;
  logic [27:0] nb_x, nb_y;
  logic [31:0] xh, xv;
  logic [7:0]  out_col, out_row;
  logic        frame_done;

  int total = 0;
  int bad = 0;

  bicubic_coord_gen dut (
    .clk(clk), .rst(rst), .cfg_valid(cfg_valid),
    .src_w(src_w), .src_h(src_h), .dst_w(dst_w), .dst_h(dst_h),
    .step_x(step_x), .step_y(step_y),
    .busy(busy), .req_valid(req_valid), .req_ready(req_ready),
    .nb_x(nb_x), .nb_y(nb_y), .xh(xh), .xv(xv),
    .out_col(out_col), .out_row(out_row), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  function automatic logic [27:0] pack4(input int a0, input int a1, input int a2, input int a3);
    return {7'(a3), 7'(a2), 7'(a1), 7'(a0)};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_frame(input logic [6:0] sw, input logic [6:0] sh, input logic [7:0] dw,
                             input logic [7:0] dh, input logic [15:0] sx, input logic [15:0] sy);
    src_w = sw; src_h = sh; dst_w = dw; dst_h = dh; step_x = sx; step_y = sy;
    cfg_valid = 1'b1;
    tick();
    cfg_valid = 1'b0;
  endtask

  task automatic wait_req(input string name, output int n);
    n = 0;
    while (req_valid !== 1'b1 && n < 50) begin
      tick();
      n++;
    end
    total++;
    if (req_valid !== 1'b1) begin
      bad++;
      $display("FAIL %s wait: req_valid=%b want=1 after %0d cycles", name, req_valid, n);
    end
  endtask

  task automatic accept();
    req_ready = 1'b1;
    tick();
    req_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; cfg_valid = 1'b1; req_ready = 1'b1;
    tick();
    tick();
    rst = 1'b0; cfg_valid = 1'b0; req_ready = 1'b0;
    total++;
    if ({busy, req_valid, frame_done} !== 3'b000) begin
      bad++;
      $display("FAIL reset_ctrl: busy/valid/done=%b want=000", {busy, req_valid, frame_done});
    end
    total++;
    if ({nb_x, nb_y, xh, xv, out_col, out_row} !== '0) begin
      bad++;
      $display("FAIL reset_data: nb_x=%h xh=%h col=%0d row=%0d want all 0", nb_x, xh, out_col, out_row);
    end
    tick();
    total++;
    if (busy !== 1'b0) begin
      bad++;
      $display("FAIL reset_cfg_ignored: busy=%b want=0", busy);
    end
    $display("test_reset: done");
  endtask

  task automatic test_raster();
    int n;
    logic [31:0] exp_xh;
    start_frame(7'd4, 7'd4, 8'd8, 8'd1, 16'h0080, 16'h0100);
    total++;
    if (busy !== 1'b1 || req_valid !== 1'b0) begin
      bad++;
      $display("FAIL raster_accept: busy=%b req_valid=%b want 1/0", busy, req_valid);
    end
    for (int c = 0; c < 8; c++) begin
      wait_req("raster", n);
      exp_xh = (c % 2 == 1) ? 32'hFF804020 : 32'hFF000000;
      total++;
      if (n != 2) begin
        bad++;
        $display("FAIL raster_latency col%0d: cycles=%0d want=2", c, n);
      end
      total++;
      if (out_col !== 8'(c) || out_row !== 8'd0) begin
        bad++;
        $display("FAIL raster_coord: col=%0d row=%0d want=%0d/0", out_col, out_row, c);
      end
      total++;
      if (xh !== exp_xh) begin
        bad++;
        $display("FAIL raster_xh col%0d: xh=%h want=%h", c, xh, exp_xh);
      end
      if (c == 0) begin
        total++;
        if (nb_x !== pack4(0, 0, 1, 2) || nb_y !== pack4(0, 0, 1, 2) || xv !== 32'hFF000000) begin
          bad++;
          $display("FAIL raster_col0: nb_x=%h nb_y=%h xv=%h want=%h/%h/ff000000",
                   nb_x, nb_y, xv, pack4(0, 0, 1, 2), pack4(0, 0, 1, 2));
        end
      end
      if (c == 3) begin
        total++;
        if (nb_x !== pack4(0, 1, 2, 3)) begin
          bad++;
          $display("FAIL raster_col3: nb_x=%h want=%h", nb_x, pack4(0, 1, 2, 3));
        end
      end
      if (c == 7) begin
        total++;
        if (nb_x !== pack4(2, 3, 3, 3)) begin
          bad++;
          $display("FAIL raster_col7: nb_x=%h want=%h", nb_x, pack4(2, 3, 3, 3));
        end
      end
      accept();
      total++;
      if (frame_done !== (c == 7) || busy !== (c != 7)) begin
        bad++;
        $display("FAIL raster_done col%0d: frame_done=%b busy=%b", c, frame_done, busy);
      end
    end
    tick();
    total++;
    if (frame_done !== 1'b0) begin
      bad++;
      $display("FAIL raster_pulse: frame_done=%b want=0", frame_done);
    end
    $display("test_raster: done");
  endtask

  task automatic test_stall();
    int n;
    start_frame(7'd4, 7'd4, 8'd2, 8'd1, 16'h0080, 16'h0000);
    wait_req("stall", n);
    for (int k = 0; k < 5; k++) begin
      tick();
      total++;
      if (req_valid !== 1'b1 || out_col !== 8'd0 || nb_x !== pack4(0, 0, 1, 2) || xh !== 32'hFF000000) begin
        bad++;
        $display("FAIL stall_hold cyc%0d: valid=%b col=%0d nb_x=%h xh=%h", k, req_valid, out_col, nb_x, xh);
      end
    end
    accept();
    wait_req("stall", n);
    total++;
    if (out_col !== 8'd1 || xh !== 32'hFF804020) begin
      bad++;
      $display("FAIL stall_advance: col=%0d xh=%h want=1/ff804020", out_col, xh);
    end
    accept();
    total++;
    if (frame_done !== 1'b1) begin
      bad++;
      $display("FAIL stall_done: frame_done=%b want=1", frame_done);
    end
    $display("test_stall: done");
  endtask

  task automatic test_frac();
    int n;
    start_frame(7'd4, 7'd4, 8'd2, 8'd1, 16'h00FF, 16'h0000);
    wait_req("frac", n);
    accept();
    wait_req("frac", n);
    total++;
    if (xh !== 32'hFFFFFEFD || nb_x !== pack4(0, 0, 1, 2)) begin
      bad++;
      $display("FAIL frac_ff: xh=%h nb_x=%h want=fffffefd/%h", xh, nb_x, pack4(0, 0, 1, 2));
    end
    accept();
    $display("test_frac: done");
  endtask

  task automatic test_single();
    start_frame(7'd4, 7'd4, 8'd1, 8'd1, 16'h0080, 16'h0080);
    cfg_valid = 1'b1;
    tick();
    cfg_valid = 1'b0;
    total++;
    if (req_valid !== 1'b0 || busy !== 1'b1) begin
      bad++;
      $display("FAIL single_cube: req_valid=%b busy=%b want 0/1", req_valid, busy);
    end
    tick();
    total++;
    if (req_valid !== 1'b1 || out_col !== 8'd0 || out_row !== 8'd0) begin
      bad++;
      $display("FAIL single_req: valid=%b col=%0d row=%0d want 1/0/0", req_valid, out_col, out_row);
    end
    accept();
    total++;
    if (frame_done !== 1'b1 || busy !== 1'b0 || req_valid !== 1'b0) begin
      bad++;
      $display("FAIL single_done: done=%b busy=%b valid=%b want 1/0/0", frame_done, busy, req_valid);
    end
    for (int k = 0; k < 4; k++) begin
      tick();
      total++;
      if (busy !== 1'b0 || req_valid !== 1'b0 || frame_done !== 1'b0) begin
        bad++;
        $display("FAIL single_idle cyc%0d: busy=%b valid=%b done=%b want 000", k, busy, req_valid, frame_done);
      end
    end
    $display("test_single: done");
  endtask

  task automatic test_reset_mid();
    int n;
    start_frame(7'd4, 7'd4, 8'd2, 8'd4, 16'h0080, 16'h0100);
    for (int k = 0; k < 4; k++) begin
      wait_req("midrst", n);
      accept();
    end
    wait_req("midrst", n);
    total++;
    if (out_row !== 8'd2 || out_col !== 8'd0 || nb_y !== pack4(1, 2, 3, 3) || xv !== 32'hFF000000) begin
      bad++;
      $display("FAIL midrst_row2: row=%0d col=%0d nb_y=%h xv=%h want 2/0/%h/ff000000",
               out_row, out_col, nb_y, xv, pack4(1, 2, 3, 3));
    end
    rst = 1'b1; req_ready = 1'b1; cfg_valid = 1'b1;
    tick();
    rst = 1'b0; req_ready = 1'b0; cfg_valid = 1'b0;
    total++;
    if ({busy, req_valid, frame_done} !== 3'b000 || {nb_x, nb_y, xh, xv, out_col, out_row} !== '0) begin
      bad++;
      $display("FAIL midrst_clear: busy=%b valid=%b done=%b nb_y=%h xv=%h row=%0d want all 0",
               busy, req_valid, frame_done, nb_y, xv, out_row);
    end
    for (int k = 0; k < 3; k++) begin
      tick();
      total++;
      if (frame_done !== 1'b0 || busy !== 1'b0) begin
        bad++;
        $display("FAIL midrst_quiet cyc%0d: done=%b busy=%b want 0/0", k, frame_done, busy);
      end
    end
    start_frame(7'd4, 7'd4, 8'd2, 8'd4, 16'h0080, 16'h0100);
    wait_req("midrst", n);
    total++;
    if (out_col !== 8'd0 || out_row !== 8'd0 || nb_y !== pack4(0, 0, 1, 2)) begin
      bad++;
      $display("FAIL midrst_restart: col=%0d row=%0d nb_y=%h want 0/0/%h", out_col, out_row, nb_y, pack4(0, 0, 1, 2));
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    $display("test_reset_mid: done");
  endtask

  task automatic test_saturate();
    int n;
    logic [31:0] exp_xh;
    logic [27:0] exp_nb;
    start_frame(7'd100, 7'd4, 8'd255, 8'd1, 16'hFFFF, 16'h0000);
    for (int c = 0; c < 255; c++) begin
      wait_req("sat", n);
      if (c == 0) begin
        exp_xh = 32'hFF000000;
        exp_nb = pack4(0, 0, 1, 2);
      end else begin
        exp_xh = (c == 2) ? 32'hFFFEFCFA : 32'hFFFFFEFD;
        exp_nb = pack4(99, 99, 99, 99);
      end
      total++;
      if (xh !== exp_xh || nb_x !== exp_nb || out_col !== 8'(c)) begin
        bad++;
        $display("FAIL sat col%0d: xh=%h nb_x=%h col=%0d want %h/%h", c, xh, nb_x, out_col, exp_xh, exp_nb);
      end
      accept();
    end
    total++;
    if (frame_done !== 1'b1 || busy !== 1'b0) begin
      bad++;
      $display("FAIL sat_done: done=%b busy=%b want 1/0", frame_done, busy);
    end
    $display("test_saturate: done");
  endtask

  initial begin
    test_reset();
    test_raster();
    test_stall();
    test_frac();
    test_single();
    test_reset_mid();
    test_saturate();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
